// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet receive framer: FSM encoding, CRC-32
// constants, preamble/SFD bytes and status error-bit positions.
package eth_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } rx_state_t;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam int ERR_CRC   = 0;
  localparam int ERR_LEN   = 1;
  localparam int ERR_ALIGN = 2;

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational one-byte step of the reflected CRC-32 (LSB-first bit order).
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  always_comb begin
    crc_next = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC_POLY) : (crc_next >> 1);
    end
  end

endmodule

// File: rtl/eth_rx_framer.sv
// RMII/MII receive framer: preamble/SFD detection, byte assembly, CRC-32 check,
// optional FCS stripping, length/error status and good/bad frame counters.
module eth_rx_framer
  import eth_pkg::*;
#(
  parameter int MII_WIDTH = 2,
  parameter int MAX_LEN   = 1518,
  parameter int MIN_LEN   = 64,
  parameter bit STRIP_FCS = 1'b1
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Rx_Dv,
  input  logic [MII_WIDTH-1:0] Rxd,
  input  logic                 Rx_Er,
  output logic [7:0]           Rx_Data,
  output logic                 Rx_Valid,
  output logic                 Rx_Sof,
  output logic                 Rx_Done,
  output logic                 Rx_Good,
  output logic [2:0]           Rx_Err_Code,
  output logic [15:0]          Rx_Len,
  output logic [15:0]          Frame_Cnt,
  output logic [15:0]          Err_Cnt
);

  localparam logic [MII_WIDTH-1:0] PRE_SYM   = PREAMBLE_BYTE[MII_WIDTH-1:0];
  localparam logic [MII_WIDTH-1:0] SFD_SYM   = SFD_BYTE[7 -: MII_WIDTH];
  localparam logic [2:0]           LAST_BEAT = 3'(8 / MII_WIDTH - 1);

  rx_state_t   state_reg, state_next;
  logic [2:0]  beat_reg;
  logic [7:0]  shift_reg;
  logic [31:0] crc_reg, crc_next;
  logic [15:0] byte_cnt_reg, len_reg, pend_len_reg;
  logic [7:0]  pipe_reg [4];
  logic [2:0]  fill_reg;
  logic        sof_pend_reg, drop_report_reg, done_pend_reg;
  logic [2:0]  err_reg, pend_err_reg, end_err, drop_err;

  logic [7:0] byte_full;
  logic in_data, data_beat, byte_done, over_max, accept;
  logic frame_end, drop_end, er_abort, len_bad, start_frame;

  assign byte_full   = {Rxd, shift_reg[7:MII_WIDTH]};
  assign in_data     = (state_reg == DATA);
  assign data_beat   = in_data && Rx_Dv && !Rx_Er;
  assign byte_done   = data_beat && (beat_reg == LAST_BEAT);
  assign over_max    = byte_done && (byte_cnt_reg >= 16'(MAX_LEN));
  assign accept      = byte_done && !over_max;
  assign er_abort    = in_data && Rx_Dv && Rx_Er;
  assign frame_end   = in_data && !Rx_Dv;
  assign drop_end    = (state_reg == DROP) && !Rx_Dv && drop_report_reg;
  assign start_frame = (state_reg == PREAMBLE) && (state_next == DATA);
  assign len_bad     = (byte_cnt_reg < 16'(MIN_LEN)) || (byte_cnt_reg > 16'(MAX_LEN));

  always_comb begin
    end_err            = err_reg;
    end_err[ERR_CRC]   = err_reg[ERR_CRC] | (crc_reg != CRC_RESIDUE);
    end_err[ERR_LEN]   = err_reg[ERR_LEN] | len_bad;
    end_err[ERR_ALIGN] = err_reg[ERR_ALIGN] | (beat_reg != 3'd0);
    drop_err           = err_reg;
    drop_err[ERR_LEN]  = err_reg[ERR_LEN] | len_bad;
  end

  eth_crc32_byte u_crc (
    .crc      (crc_reg),
    .data     (byte_full),
    .crc_next (crc_next)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (Rx_Dv && Rxd == PRE_SYM) state_next = PREAMBLE;
      PREAMBLE: begin
        if (!Rx_Dv)              state_next = IDLE;
        else if (Rxd == PRE_SYM) state_next = PREAMBLE;
        else if (Rxd == SFD_SYM) state_next = DATA;
        else                     state_next = DROP;
      end
      DATA: begin
        if (!Rx_Dv)                  state_next = IDLE;
        else if (Rx_Er || over_max)  state_next = DROP;
      end
      DROP:     if (!Rx_Dv) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // FCS holding pipeline: stage 3 is the oldest byte, delivered once four are held.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        always_ff @(posedge Clk or negedge Rst_n) begin
          if (!Rst_n)      pipe_reg[gi] <= '0;
          else if (accept) pipe_reg[gi] <= byte_full;
        end
      end else begin : g_tail
        always_ff @(posedge Clk or negedge Rst_n) begin
          if (!Rst_n)      pipe_reg[gi] <= '0;
          else if (accept) pipe_reg[gi] <= pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      beat_reg <= '0; shift_reg <= '0; crc_reg <= CRC_INIT;
      byte_cnt_reg <= '0; len_reg <= '0; fill_reg <= '0; err_reg <= '0;
      sof_pend_reg <= 1'b0; drop_report_reg <= 1'b0; done_pend_reg <= 1'b0;
      pend_err_reg <= '0; pend_len_reg <= '0;
      Rx_Data <= '0; Rx_Valid <= 1'b0; Rx_Sof <= 1'b0; Rx_Done <= 1'b0;
      Rx_Good <= 1'b0; Rx_Err_Code <= '0; Rx_Len <= '0;
      Frame_Cnt <= '0; Err_Cnt <= '0;
    end else begin
      Rx_Valid      <= 1'b0;
      Rx_Sof        <= 1'b0;
      Rx_Done       <= 1'b0;
      done_pend_reg <= 1'b0;

      if (start_frame) begin
        beat_reg <= '0; shift_reg <= '0; crc_reg <= CRC_INIT;
        byte_cnt_reg <= '0; len_reg <= '0; fill_reg <= '0; err_reg <= '0;
        sof_pend_reg <= 1'b1;
      end

      if (data_beat) begin
        shift_reg <= byte_full;
        beat_reg  <= (beat_reg == LAST_BEAT) ? 3'd0 : beat_reg + 3'd1;
      end

      if (accept) begin
        crc_reg      <= crc_next;
        byte_cnt_reg <= byte_cnt_reg + 16'd1;
        if (!STRIP_FCS || fill_reg == 3'd4) begin
          Rx_Data      <= STRIP_FCS ? pipe_reg[3] : byte_full;
          Rx_Valid     <= 1'b1;
          Rx_Sof       <= sof_pend_reg;
          sof_pend_reg <= 1'b0;
          if (len_reg < 16'(MAX_LEN)) len_reg <= len_reg + 16'd1;
        end
        if (fill_reg != 3'd4) fill_reg <= fill_reg + 3'd1;
      end

      if (er_abort) err_reg[ERR_ALIGN] <= 1'b1;
      if (over_max) err_reg[ERR_LEN]   <= 1'b1;

      // Only drops out of DATA owe the host an end-of-frame status.
      if (state_reg == PREAMBLE)             drop_report_reg <= 1'b0;
      else if (in_data && state_next == DROP) drop_report_reg <= 1'b1;

      if (frame_end || drop_end) begin
        done_pend_reg <= 1'b1;
        pend_err_reg  <= frame_end ? end_err : drop_err;
        pend_len_reg  <= len_reg;
      end

      if (done_pend_reg) begin
        Rx_Done     <= 1'b1;
        Rx_Good     <= (pend_err_reg == 3'd0);
        Rx_Err_Code <= pend_err_reg;
        Rx_Len      <= pend_len_reg;
        if (pend_err_reg == 3'd0) begin
          if (Frame_Cnt != 16'hFFFF) Frame_Cnt <= Frame_Cnt + 16'd1;
        end else begin
          if (Err_Cnt != 16'hFFFF) Err_Cnt <= Err_Cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_framer.sv
// Directed bench for eth_rx_framer: an RMII instance with FCS stripping and an
// MII instance delivering FCS, driven with hand-built frames.
module tb_eth_rx_framer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       dv_a = 1'b0, er_a = 1'b0;
  logic [1:0] rxd_a = '0;
  logic [7:0] a_data;  logic a_valid, a_sof, a_done, a_good;
  logic [2:0] a_err;   logic [15:0] a_len, a_fc, a_ec;

  logic       dv_b = 1'b0, er_b = 1'b0;
  logic [3:0] rxd_b = '0;
  logic [7:0] b_data;  logic b_valid, b_sof, b_done, b_good;
  logic [2:0] b_err;   logic [15:0] b_len, b_fc, b_ec;

  eth_rx_framer #(.MII_WIDTH(2), .MAX_LEN(1518), .MIN_LEN(64), .STRIP_FCS(1'b1)) dut_a (
    .Clk(clk), .Rst_n(rst_n), .Rx_Dv(dv_a), .Rxd(rxd_a), .Rx_Er(er_a),
    .Rx_Data(a_data), .Rx_Valid(a_valid), .Rx_Sof(a_sof), .Rx_Done(a_done),
    .Rx_Good(a_good), .Rx_Err_Code(a_err), .Rx_Len(a_len),
    .Frame_Cnt(a_fc), .Err_Cnt(a_ec));

  eth_rx_framer #(.MII_WIDTH(4), .MAX_LEN(1518), .MIN_LEN(64), .STRIP_FCS(1'b0)) dut_b (
    .Clk(clk), .Rst_n(rst_n), .Rx_Dv(dv_b), .Rxd(rxd_b), .Rx_Er(er_b),
    .Rx_Data(b_data), .Rx_Valid(b_valid), .Rx_Sof(b_sof), .Rx_Done(b_done),
    .Rx_Good(b_good), .Rx_Err_Code(b_err), .Rx_Len(b_len),
    .Frame_Cnt(b_fc), .Err_Cnt(b_ec));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitors, sampled on the falling edge.
  logic [7:0] qa[$], qb[$];
  int a_sof_cnt = 0, a_sof_idx = -1, a_done_cnt = 0;
  int b_sof_cnt = 0, b_done_cnt = 0;
  always @(negedge clk) begin
    if (a_valid) begin
      qa.push_back(a_data);
      if (a_sof) begin a_sof_cnt++; a_sof_idx = qa.size() - 1; end
    end
    if (a_done) a_done_cnt++;
    if (b_valid) begin
      qb.push_back(b_data);
      if (b_sof) b_sof_cnt++;
    end
    if (b_done) b_done_cnt++;
  end

  logic [7:0] fb [0:1699];
  int flen, last_lat, done_before_end;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build_frame(input int np, input bit flip);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < np; i++) begin
      fb[i] = 8'(i);
      c = crc_upd(c, fb[i]);
    end
    c = ~c;
    for (int j = 0; j < 4; j++) fb[np + j] = c[8*j +: 8];
    if (flip) fb[np + 3] = fb[np + 3] ^ 8'h01;
    flen = np + 4;
  endtask

  task automatic drive(input int sel, input logic dv, input logic er, input logic [3:0] d);
    @(negedge clk);
    if (sel == 0) begin dv_a = dv; er_a = er; rxd_a = d[1:0]; end
    else          begin dv_b = dv; er_b = er; rxd_b = d;      end
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input bit er);
    int w;
    w = (sel == 0) ? 2 : 4;
    for (int k = 0; k < 8 / w; k++)
      drive(sel, 1'b1, er && (k == 0), 4'((b >> (k * w)) & ((sel == 0) ? 8'h03 : 8'h0F)));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends preamble, SFD and fb[0:n-1]; measures falling-edge count from Rx_Dv low to Rx_Done.
  task automatic send_frame(input int sel, input int n, input int er_at, input int rst_at);
    for (int i = 0; i < 7; i++) send_byte(sel, 8'h55, 1'b0);
    send_byte(sel, 8'hD5, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        @(negedge clk);
        rst_n = 1'b0; dv_a = 1'b0; dv_b = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(4);
        return;
      end
      send_byte(sel, fb[i], i == er_at);
    end
    done_before_end = (sel == 0) ? a_done_cnt : b_done_cnt;
    drive(sel, 1'b0, 1'b0, 4'h0);
    last_lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if ((sel == 0 ? a_done : b_done) && last_lat == 0) last_lat = k;
    end
    idle(2);
  endtask

  int base;

  initial begin
    idle(3);
    check("rst_a_valid", a_valid, 0);
    check("rst_a_done", a_done, 0);
    check("rst_a_data", a_data, 0);
    check("rst_a_len", a_len, 0);
    check("rst_a_fc", a_fc, 0);
    check("rst_b_ec", b_ec, 0);
    rst_n = 1'b1;
    idle(2);

    // Good 60-byte payload with FCS stripped.
    build_frame(60, 1'b0);
    qa.delete(); a_sof_cnt = 0; a_sof_idx = -1; base = a_done_cnt;
    send_frame(0, flen, -1, -1);
    check("a_valid_cnt", qa.size(), 60);
    for (int i = 0; i < 60; i++) check("a_data", (i < qa.size()) ? qa[i] : 8'hxx, 8'(i));
    check("a_sof_cnt", a_sof_cnt, 1);
    check("a_sof_idx", a_sof_idx, 0);
    check("a_done_cnt", a_done_cnt - base, 1);
    check("a_done_lat", last_lat, 2);
    check("a_good", a_good, 1);
    check("a_err", a_err, 3'b000);
    check("a_len", a_len, 60);
    check("a_fc", a_fc, 1);

    // Same frame with a corrupted FCS byte.
    build_frame(60, 1'b1);
    qa.delete();
    send_frame(0, flen, -1, -1);
    check("crc_good", a_good, 0);
    check("crc_err", a_err, 3'b001);
    check("crc_len", a_len, 60);
    check("crc_ec", a_ec, 1);

    // Rx_Er at payload byte 10: bytes 0..5 are the only ones released.
    build_frame(60, 1'b0);
    qa.delete(); base = a_done_cnt;
    send_frame(0, flen, 10, -1);
    check("er_valid_cnt", qa.size(), 6);
    check("er_done_cnt", a_done_cnt - base, 1);
    check("er_bit2", a_err[2], 1);
    check("er_good", a_good, 0);
    check("er_ec", a_ec, 2);

    // Preamble ending without SFD, then preamble followed by a bad symbol.
    base = a_done_cnt;
    for (int i = 0; i < 7; i++) send_byte(0, 8'h55, 1'b0);
    drive(0, 1'b0, 1'b0, 4'h0);
    idle(6);
    check("nosfd_done", a_done_cnt - base, 0);
    for (int i = 0; i < 7; i++) send_byte(0, 8'h55, 1'b0);
    send_byte(0, 8'h00, 1'b0);
    send_byte(0, 8'h00, 1'b0);
    drive(0, 1'b0, 1'b0, 4'h0);
    idle(6);
    check("badsym_done", a_done_cnt - base, 0);
    check("badsym_ec", a_ec, 2);

    // MII, FCS delivered: 40-byte frame is a runt with a valid CRC.
    build_frame(36, 1'b0);
    qb.delete(); b_sof_cnt = 0;
    send_frame(1, flen, -1, -1);
    check("b40_valid_cnt", qb.size(), 40);
    check("b40_first", (qb.size() > 0) ? qb[0] : 8'hxx, 8'h00);
    check("b40_fcs3", (qb.size() > 39) ? qb[39] : 8'hxx, fb[39]);
    check("b40_sof_cnt", b_sof_cnt, 1);
    check("b40_len", b_len, 40);
    check("b40_err", b_err, 3'b010);
    check("b40_ec", b_ec, 1);

    // 1600-byte frame exceeds MAX_LEN: delivery stops at byte 1518.
    build_frame(1596, 1'b0);
    qb.delete(); base = b_done_cnt;
    send_frame(1, flen, -1, -1);
    check("big_valid_cnt", qb.size(), 1518);
    check("big_last", (qb.size() > 1517) ? qb[1517] : 8'hxx, 8'hED);
    check("big_no_early_done", done_before_end - base, 0);
    check("big_done_lat", last_lat, 2);
    check("big_len", b_len, 1518);
    check("big_err1", b_err[1], 1);
    check("big_fc", b_fc, 0);

    // Reset at payload byte 20, then a clean frame.
    build_frame(60, 1'b0);
    base = a_done_cnt;
    send_frame(0, flen, -1, 20);
    check("rst_mid_done", a_done_cnt - base, 0);
    check("rst_mid_fc", a_fc, 0);
    check("rst_mid_ec", a_ec, 0);
    qa.delete();
    send_frame(0, flen, -1, -1);
    check("post_rst_done", a_done_cnt - base, 1);
    check("post_rst_good", a_good, 1);
    check("post_rst_len", a_len, 60);
    check("post_rst_fc", a_fc, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
